// File: rtl/ex_pkg.sv
// Shared execute-stage definitions: default sizes, requester indices and
// the index-width helper used by the issue arbiter and its picker.
package ex_pkg;

    localparam int EX_N_REQ  = 4;
    localparam int EX_DATA_W = 32;

    localparam int REQ_DEC    = 0;
    localparam int REQ_REPLAY = 1;
    localparam int REQ_SYS    = 2;
    localparam int REQ_SPARE  = 3;

    // An index field is never narrower than one bit, even for two requesters.
    function automatic int ex_id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef logic [ex_id_w(EX_N_REQ)-1:0] ex_req_id_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate requests so ptr sits at bit 0,
// take the lowest set bit, then rotate the one-hot result back.
module rr_pick
    import ex_pkg::*;
#(
    parameter int N = 4,
    parameter int W = ex_id_w(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         any_o,
    output logic [W-1:0] idx_o,
    output logic [N-1:0] onehot_o
);

    logic [N-1:0] rot;
    logic [N-1:0] seen;
    logic [N-1:0] first;

    // Doubling the vector turns the rotate into a plain shift.
    assign rot = N'({req_i, req_i} >> ptr_i);

    always_comb begin
        seen = '0;
        for (int k = 1; k < N; k++) begin
            seen[k] = seen[k-1] | rot[k-1];
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_first
        assign first[gi] = rot[gi] & ~seen[gi];
    end

    assign onehot_o = N'(({first, first} << ptr_i) >> N);
    assign any_o    = |req_i;

    always_comb begin
        idx_o = '0;
        for (int k = 0; k < N; k++) begin
            if (onehot_o[k]) begin
                idx_o = idx_o | W'(k);
            end
        end
    end

endmodule

// File: rtl/ex_issue_arb.sv
// Round-robin issue arbiter with a registered valid/ready output slice that
// feeds the execute stage; supports flush and a per-requester enable mask.
module ex_issue_arb
    import ex_pkg::*;
#(
    parameter int N_REQ  = EX_N_REQ,
    parameter int DATA_W = EX_DATA_W,
    parameter int ID_W   = ex_id_w(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    output logic [N_REQ-1:0]        req_ready_o,
    input  logic [N_REQ-1:0]        req_en_i,
    input  logic                    flush_i,
    output logic                    valid_ro,
    output logic [DATA_W-1:0]       data_ro,
    output logic [ID_W-1:0]         id_ro,
    input  logic                    ready_i
);

    if (N_REQ < 2 || N_REQ > 16) begin : g_bad_param
        $error("ex_issue_arb: N_REQ must be in 2..16");
    end

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [ID_W-1:0]   id_q,    id_d;
    logic [ID_W-1:0]   ptr_q,   ptr_d;

    logic [N_REQ-1:0]  eligible;
    logic              any_eligible;
    logic [ID_W-1:0]   win_idx;
    logic [N_REQ-1:0]  win_onehot;
    logic              cke;
    logic              grant;
    logic [DATA_W-1:0] payload [N_REQ];
    logic [DATA_W-1:0] data_sel;

    assign eligible = req_valid_i & req_en_i;

    rr_pick #(
        .N (N_REQ),
        .W (ID_W)
    ) u_pick (
        .req_i    (eligible),
        .ptr_i    (ptr_q),
        .any_o    (any_eligible),
        .idx_o    (win_idx),
        .onehot_o (win_onehot)
    );

    assign cke   = ~valid_q | ready_i;
    assign grant = cke & ~flush_i & any_eligible;

    // Gated by rst so no requester sees an acknowledge while reset is held.
    assign req_ready_o = (grant & ~rst) ? win_onehot : '0;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_payload
        assign payload[gi] = req_data_i[gi*DATA_W +: DATA_W];
    end

    // AND-OR mux keyed by the one-hot winner.
    always_comb begin
        data_sel = '0;
        for (int k = 0; k < N_REQ; k++) begin
            data_sel = data_sel | ({DATA_W{win_onehot[k]}} & payload[k]);
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (grant) begin
            valid_d = 1'b1;
            data_d  = data_sel;
            id_d    = win_idx;
            ptr_d   = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + ID_W'(1);
        end else if (cke) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    assign valid_ro = valid_q;
    assign data_ro  = data_q;
    assign id_ro    = id_q;

endmodule

// File: tb/tb_ex_issue_arb.sv
// Self-checking bench for ex_issue_arb: directed scenarios plus a random run,
// all compared against a rule-level model of the arbiter kept here.
module tb_ex_issue_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_en;
    logic            flush;
    logic            valid_ro;
    logic [DW-1:0]   data_ro;
    logic [IW-1:0]   id_ro;
    logic            ready;

    logic [DW-1:0]   pay [N];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit            m_valid;
    logic [DW-1:0] m_data;
    int            m_id;
    int            m_ptr;

    logic [N-1:0]  obs_ready;
    bit            last_grant;
    int            last_w;

    ex_issue_arb #(.N_REQ(N), .DATA_W(DW), .ID_W(IW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .req_en_i    (req_en),
        .flush_i     (flush),
        .valid_ro    (valid_ro),
        .data_ro     (data_ro),
        .id_ro       (id_ro),
        .ready_i     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int k = 0; k < N; k++) req_data[k*DW +: DW] = pay[k];
    end

    task automatic model_reset();
        m_valid = 0;
        m_data  = '0;
        m_id    = 0;
        m_ptr   = 0;
    endtask

    // One clock: check DUT against model at negedge, advance model at posedge.
    task automatic cycle();
        logic [N-1:0]  elig;
        logic [N-1:0]  er;
        logic [IW-1:0] mid;
        bit            cke;
        bit            g;
        int            w;
        elig = req_valid & req_en;
        cke  = !m_valid || ready;
        w    = -1;
        for (int i = 0; i < N; i++) begin
            int j;
            j = (m_ptr + i) % N;
            if (w < 0 && elig[j]) w = j;
        end
        g  = cke && !flush && (w >= 0);
        er = '0;
        if (g) er[w] = 1'b1;
        mid = m_id[IW-1:0];
        @(negedge clk);
        obs_ready = req_ready;
        n_vec++;
        if (req_ready !== er) begin
            n_err++;
            $display("FAIL req_ready: got %b want %b at %0t", req_ready, er, $time);
        end
        n_vec++;
        if ($countones(req_ready) > 1) begin
            n_err++;
            $display("FAIL ready_onehot: got %b want at most one bit", req_ready);
        end
        n_vec++;
        if (valid_ro !== m_valid) begin
            n_err++;
            $display("FAIL valid_ro: got %b want %b at %0t", valid_ro, m_valid, $time);
        end
        n_vec++;
        if (data_ro !== m_data || id_ro !== mid) begin
            n_err++;
            $display("FAIL data_id: got %h/%0d want %h/%0d at %0t", data_ro, id_ro, m_data, mid, $time);
        end
        @(posedge clk);
        if (flush) begin
            m_valid = 0;
        end else if (g) begin
            m_valid = 1;
            m_data  = pay[w];
            m_id    = w;
            m_ptr   = (w + 1) % N;
        end else if (cke) begin
            m_valid = 0;
        end
        last_grant = g;
        last_w     = w;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        req_valid = '1;
        req_en    = '1;
        ready     = 1'b1;
        flush     = 1'b0;
        for (int k = 0; k < N; k++) pay[k] = k * 32'h1111;
        #2;
        n_vec++;
        if (req_ready !== '0 || valid_ro !== 1'b0 || data_ro !== '0 || id_ro !== '0) begin
            n_err++;
            $display("FAIL reset_state: got rdy=%b v=%b d=%h id=%0d want all zero", req_ready, valid_ro, data_ro, id_ro);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) cycle();
        // Mid-traffic async reset, checked before any clock edge.
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (valid_ro !== 1'b0 || data_ro !== '0 || id_ro !== '0 || req_ready !== '0) begin
            n_err++;
            $display("FAIL async_reset: got v=%b d=%h id=%0d rdy=%b want zeros", valid_ro, data_ro, id_ro, req_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cycle();
        n_vec++;
        if (valid_ro !== 1'b1 || id_ro !== 2'd0) begin
            n_err++;
            $display("FAIL first_grant_after_reset: got v=%b id=%0d want v=1 id=0", valid_ro, id_ro);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid = '1;
        req_en    = '1;
        ready     = 1'b1;
        for (int k = 0; k < N; k++) pay[k] = k * 32'h1111;
        for (int i = 0; i < 8; i++) begin
            cycle();
            n_vec++;
            if (valid_ro !== 1'b1 || id_ro !== IW'(i % N) || data_ro !== (i % N) * 32'h1111) begin
                n_err++;
                $display("FAIL rr_seq[%0d]: got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                         i, valid_ro, id_ro, data_ro, i % N, (i % N) * 32'h1111);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 4'b0100;
        req_en    = '1;
        ready     = 1'b1;
        pay[2]    = 32'hB2B2_0001;
        cycle();
        n_vec++;
        if (valid_ro !== 1'b1 || id_ro !== 2'd2 || data_ro !== 32'hB2B2_0001) begin
            n_err++;
            $display("FAIL bp_first: got v=%b id=%0d d=%h want v=1 id=2 d=b2b20001", valid_ro, id_ro, data_ro);
        end
        pay[2] = 32'hB2B2_0002;
        ready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_vec++;
            if (obs_ready !== 4'b0000 || valid_ro !== 1'b1 || data_ro !== 32'hB2B2_0001) begin
                n_err++;
                $display("FAIL bp_stall[%0d]: got rdy=%b v=%b d=%h want rdy=0000 v=1 d=b2b20001",
                         i, obs_ready, valid_ro, data_ro);
            end
        end
        ready = 1'b1;
        cycle();
        n_vec++;
        if (obs_ready !== 4'b0100 || data_ro !== 32'hB2B2_0002) begin
            n_err++;
            $display("FAIL bp_resume: got rdy=%b d=%h want rdy=0100 d=b2b20002", obs_ready, data_ro);
        end
    endtask

    task automatic test_mask();
        int seq [3] = '{0, 1, 3};
        do_reset();
        req_valid = '1;
        req_en    = 4'b1011;
        ready     = 1'b1;
        for (int k = 0; k < N; k++) pay[k] = 32'hC000_0000 + k;
        for (int i = 0; i < 6; i++) begin
            cycle();
            n_vec++;
            if (id_ro !== IW'(seq[i % 3]) || obs_ready[2] !== 1'b0) begin
                n_err++;
                $display("FAIL mask_seq[%0d]: got id=%0d rdy=%b want id=%0d rdy[2]=0",
                         i, id_ro, obs_ready, seq[i % 3]);
            end
        end
        req_en = '1;
    endtask

    task automatic test_flush();
        do_reset();
        req_valid = '1;
        req_en    = '1;
        ready     = 1'b1;
        for (int k = 0; k < N; k++) pay[k] = 32'hA000_0000 + k;
        cycle();
        ready = 1'b0;
        cycle();
        flush = 1'b1;
        cycle();
        n_vec++;
        if (obs_ready !== 4'b0000 || valid_ro !== 1'b0 || data_ro !== 32'hA000_0000 || id_ro !== 2'd0) begin
            n_err++;
            $display("FAIL flush_stall: got rdy=%b v=%b d=%h id=%0d want rdy=0000 v=0 d=a0000000 id=0",
                     obs_ready, valid_ro, data_ro, id_ro);
        end
        flush = 1'b0;
        ready = 1'b1;
        cycle();
        n_vec++;
        if (valid_ro !== 1'b1 || id_ro !== 2'd1 || data_ro !== 32'hA000_0001) begin
            n_err++;
            $display("FAIL flush_resume: got v=%b id=%0d d=%h want v=1 id=1 d=a0000001", valid_ro, id_ro, data_ro);
        end
    endtask

    task automatic test_random();
        int wait_cnt [N];
        do_reset();
        req_en = '1;
        for (int k = 0; k < N; k++) begin
            wait_cnt[k] = 0;
            req_valid[k] = (k == 0) ? 1'b1 : 1'($urandom_range(1));
            pay[k] = $urandom;
        end
        for (int i = 0; i < 1500; i++) begin
            flush = ($urandom_range(15) == 0);
            ready = ($urandom_range(3) != 0);
            cycle();
            for (int k = 0; k < N; k++) begin
                if (obs_ready[k]) begin
                    n_vec++;
                    if (wait_cnt[k] > N - 1) begin
                        n_err++;
                        $display("FAIL starvation[%0d]: got %0d other grants want at most %0d", k, wait_cnt[k], N - 1);
                    end
                    wait_cnt[k]  = 0;
                    req_valid[k] = (k == 0) ? 1'b1 : 1'($urandom_range(1));
                    pay[k]       = $urandom;
                end else if (req_valid[k]) begin
                    if (|obs_ready) wait_cnt[k]++;
                end else if ($urandom_range(3) == 0) begin
                    req_valid[k] = 1'b1;
                    pay[k]       = $urandom;
                    wait_cnt[k]  = 0;
                end
            end
        end
        flush = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_en    = '0;
        flush     = 1'b0;
        ready     = 1'b0;
        for (int k = 0; k < N; k++) pay[k] = '0;
        model_reset();
        #1;
        rst = 1'b1;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_mask();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
